// File: rtl/sram_arbiter.sv
// Shares one asynchronous 16-bit SRAM between a one-entry buffered byte download writer and CHANNELS byte readers.
// Define SRAM_ARBITER_RR_EN for round-robin read arbitration; otherwise the lowest-index requester wins.
module sram_arbiter #(
  parameter int AW            = 20,
  parameter int CHANNELS      = 2,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       dlWr,
  input  logic [AW:0]                dlA,
  input  logic [7:0]                 dlD,
  output logic                       dlFull,
  output logic                       dlOvr,
  input  logic [CHANNELS-1:0]        rdReq,
  input  logic [CHANNELS*(AW+1)-1:0] rdA,
  output logic [7:0]                 rdD,
  output logic [CHANNELS-1:0]        rdAck,
  output logic [AW-1:0]              sramA,
  output logic                       sramUb,
  output logic                       sramLb,
  output logic                       sramOe,
  output logic                       sramWe,
  output logic [15:0]                sramDqO,
  output logic                       sramDqOe,
  input  logic [15:0]                sramDqI
);

  localparam int CW   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNTW = $clog2(ACCESS_CYCLES);
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(ACCESS_CYCLES - 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state_q, state_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic                is_read_q, is_read_d;
  logic [CW-1:0]       chan_q, chan_d;
  logic                lane_q, lane_d;
  logic                buf_full_q, buf_full_d;
  logic [AW:0]         buf_a_q, buf_a_d;
  logic [7:0]          buf_d_q, buf_d_d;
  logic                ovr_q, ovr_d;
  logic [7:0]          rd_data_q, rd_data_d;
  logic [CHANNELS-1:0] rd_ack_q, rd_ack_d;
  logic [AW-1:0]       sram_a_q, sram_a_d;
  logic                ub_q, ub_d, lb_q, lb_d, oe_q, oe_d, we_q, we_d;
  logic                dq_oe_q, dq_oe_d;
  logic [15:0]         dq_o_q, dq_o_d;

  logic [AW:0]         rd_a_arr [CHANNELS];
  logic                rd_any;
  logic [CW-1:0]       rd_sel;
  logic [AW:0]         rd_addr;
  logic                wr_pending;
  logic [AW:0]         wr_addr;
  logic [7:0]          wr_data;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) rd_a_arr[i] = rdA[i*(AW+1) +: AW+1];
  end

`ifdef SRAM_ARBITER_RR_EN
  logic [CW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] rr_idx;

  // Scan from the highest offset down so the channel nearest the pointer is the last to overwrite rd_sel.
  always_comb begin
    rd_any = 1'b0;
    rd_sel = '0;
    rr_idx = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      rr_idx = CW'((int'(ptr_q) + i) % CHANNELS);
      if (rdReq[rr_idx]) begin
        rd_any = 1'b1;
        rd_sel = rr_idx;
      end
    end
  end
`else
  always_comb begin
    rd_any = 1'b0;
    rd_sel = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (rdReq[i]) begin
        rd_any = 1'b1;
        rd_sel = CW'(i);
      end
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_read_d  = is_read_q;
    chan_d     = chan_q;
    lane_d     = lane_q;
    buf_full_d = buf_full_q;
    buf_a_d    = buf_a_q;
    buf_d_d    = buf_d_q;
    ovr_d      = ovr_q;
    rd_data_d  = rd_data_q;
    rd_ack_d   = '0;
    sram_a_d   = sram_a_q;
    ub_d       = ub_q;
    lb_d       = lb_q;
    oe_d       = oe_q;
    we_d       = we_q;
    dq_oe_d    = dq_oe_q;
    dq_o_d     = dq_o_q;
`ifdef SRAM_ARBITER_RR_EN
    ptr_d      = ptr_q;
`endif
    rd_addr    = rd_a_arr[rd_sel];
    wr_pending = buf_full_q | dlWr;
    wr_addr    = buf_full_q ? buf_a_q : dlA;
    wr_data    = buf_full_q ? buf_d_q : dlD;

    // A strobe seen while idle with an empty buffer goes straight into the slot instead of the buffer.
    if (state_q == IDLE && wr_pending) buf_full_d = 1'b0;
    if (dlWr && !(state_q == IDLE && !buf_full_q)) begin
      if (!buf_full_q || state_q == IDLE) begin
        buf_full_d = 1'b1;
        buf_a_d    = dlA;
        buf_d_d    = dlD;
      end else begin
        ovr_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (wr_pending) begin
          state_d   = ACCESS;
          cnt_d     = CNT_LOAD;
          is_read_d = 1'b0;
          lane_d    = wr_addr[0];
          sram_a_d  = wr_addr[AW:1];
          ub_d      = ~wr_addr[0];
          lb_d      = wr_addr[0];
          oe_d      = 1'b1;
          we_d      = 1'b0;
          dq_oe_d   = 1'b1;
          dq_o_d    = {wr_data, wr_data};
        end else if (rd_any) begin
          state_d   = ACCESS;
          cnt_d     = CNT_LOAD;
          is_read_d = 1'b1;
          chan_d    = rd_sel;
          lane_d    = rd_addr[0];
          sram_a_d  = rd_addr[AW:1];
          ub_d      = ~rd_addr[0];
          lb_d      = rd_addr[0];
          oe_d      = 1'b0;
          we_d      = 1'b1;
          dq_oe_d   = 1'b0;
          dq_o_d    = '0;
`ifdef SRAM_ARBITER_RR_EN
          ptr_d     = (int'(rd_sel) == CHANNELS - 1) ? '0 : rd_sel + CW'(1);
`endif
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          state_d  = IDLE;
          sram_a_d = '0;
          ub_d     = 1'b1;
          lb_d     = 1'b1;
          oe_d     = 1'b1;
          we_d     = 1'b1;
          dq_oe_d  = 1'b0;
          dq_o_d   = '0;
          if (is_read_q) begin
            rd_data_d        = lane_q ? sramDqI[15:8] : sramDqI[7:0];
            rd_ack_d[chan_q] = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNTW'(1);
          // Release the write strobe one cycle early so address and data are held past its rising edge.
          if (!is_read_q && cnt_q == CNTW'(1)) we_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_read_q  <= 1'b0;
      chan_q     <= '0;
      lane_q     <= 1'b0;
      buf_full_q <= 1'b0;
      buf_a_q    <= '0;
      buf_d_q    <= '0;
      ovr_q      <= 1'b0;
      rd_data_q  <= '0;
      rd_ack_q   <= '0;
      sram_a_q   <= '0;
      ub_q       <= 1'b1;
      lb_q       <= 1'b1;
      oe_q       <= 1'b1;
      we_q       <= 1'b1;
      dq_oe_q    <= 1'b0;
      dq_o_q     <= '0;
`ifdef SRAM_ARBITER_RR_EN
      ptr_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_read_q  <= is_read_d;
      chan_q     <= chan_d;
      lane_q     <= lane_d;
      buf_full_q <= buf_full_d;
      buf_a_q    <= buf_a_d;
      buf_d_q    <= buf_d_d;
      ovr_q      <= ovr_d;
      rd_data_q  <= rd_data_d;
      rd_ack_q   <= rd_ack_d;
      sram_a_q   <= sram_a_d;
      ub_q       <= ub_d;
      lb_q       <= lb_d;
      oe_q       <= oe_d;
      we_q       <= we_d;
      dq_oe_q    <= dq_oe_d;
      dq_o_q     <= dq_o_d;
`ifdef SRAM_ARBITER_RR_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign dlFull   = buf_full_q;
  assign dlOvr    = ovr_q;
  assign rdD      = rd_data_q;
  assign rdAck    = rd_ack_q;
  assign sramA    = sram_a_q;
  assign sramUb   = ub_q;
  assign sramLb   = lb_q;
  assign sramOe   = oe_q;
  assign sramWe   = we_q;
  assign sramDqO  = dq_o_q;
  assign sramDqOe = dq_oe_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus random traffic checked each cycle against a slot-level model.
module tb_sram_arbiter;
  localparam int AW = 20;
  localparam int CH = 2;
  localparam int AC = 2;
  localparam int BW = AW + 1;

  logic              clock = 1'b0;
  logic              reset;
  logic              dl_wr;
  logic [AW:0]       dl_a;
  logic [7:0]        dl_d;
  logic [CH-1:0]     rd_req;
  logic [CH*BW-1:0]  rd_a;
  logic [15:0]       sram_dq_i;
  wire               dl_full, dl_ovr;
  wire  [7:0]        rd_d;
  wire  [CH-1:0]     rd_ack;
  wire  [AW-1:0]     sram_a;
  wire               sram_ub, sram_lb, sram_oe, sram_we, sram_dq_oe;
  wire  [15:0]       sram_dq_o;

  sram_arbiter #(.AW(AW), .CHANNELS(CH), .ACCESS_CYCLES(AC)) dut (
    .clock(clock), .reset(reset),
    .dlWr(dl_wr), .dlA(dl_a), .dlD(dl_d), .dlFull(dl_full), .dlOvr(dl_ovr),
    .rdReq(rd_req), .rdA(rd_a), .rdD(rd_d), .rdAck(rd_ack),
    .sramA(sram_a), .sramUb(sram_ub), .sramLb(sram_lb), .sramOe(sram_oe), .sramWe(sram_we),
    .sramDqO(sram_dq_o), .sramDqOe(sram_dq_oe), .sramDqI(sram_dq_i)
  );

  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int dut_grants[$];

  // Model: at most one slot in flight, described by its last cycle number and its payload.
  bit            m_slot, m_read, m_buf, m_ovr;
  int            m_last, m_chan, m_rr;
  logic [AW:0]   m_addr, m_buf_a;
  logic [7:0]    m_data, m_buf_d, m_rdd;
  logic [CH-1:0] m_ack;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, got, exp);
    end
  endtask

  task automatic modelStep();
    bit idle;
    int g, c;
    if (reset) begin
      m_slot = 0; m_buf = 0; m_ovr = 0; m_ack = '0; m_rdd = '0; m_rr = 0;
      return;
    end
    idle  = !m_slot;
    m_ack = '0;
    if (m_slot && cyc == m_last) begin
      if (m_read) begin
        m_ack = CH'(1) << m_chan;
        m_rdd = m_addr[0] ? sram_dq_i[15:8] : sram_dq_i[7:0];
      end
      m_slot = 0;
    end
    if (idle && (m_buf || dl_wr)) begin
      m_slot = 1; m_read = 0; m_last = cyc + AC;
      if (m_buf) begin
        m_addr = m_buf_a; m_data = m_buf_d;
        m_buf = dl_wr; m_buf_a = dl_a; m_buf_d = dl_d;
      end else begin
        m_addr = dl_a; m_data = dl_d;
      end
    end else begin
      if (dl_wr) begin
        if (!m_buf) begin m_buf = 1; m_buf_a = dl_a; m_buf_d = dl_d; end
        else m_ovr = 1;
      end
      if (idle) begin
        g = -1;
        for (int k = 0; k < CH; k++) begin
`ifdef SRAM_ARBITER_RR_EN
          c = (m_rr + k) % CH;
`else
          c = k;
`endif
          if (g < 0 && rd_req[c]) g = c;
        end
        if (g >= 0) begin
          m_slot = 1; m_read = 1; m_last = cyc + AC; m_chan = g;
          m_addr = rd_a[g*BW +: BW];
          m_rr = (g + 1) % CH;
        end
      end
    end
  endtask

  task automatic checkCycle();
    logic [AW-1:0] e_a;
    logic [4:0]    e_ctl;
    logic [15:0]   e_dqo;
    e_a = '0; e_ctl = 5'b11110; e_dqo = '0;
    if (m_slot) begin
      e_a   = m_addr[AW:1];
      e_ctl = {~m_addr[0], m_addr[0], ~m_read, m_read ? 1'b1 : (cyc == m_last), ~m_read};
      e_dqo = m_read ? 16'h0 : {m_data, m_data};
    end
    checkOutput("sramA", sram_a, e_a);
    checkOutput("ub_lb_oe_we_dqoe", {sram_ub, sram_lb, sram_oe, sram_we, sram_dq_oe}, e_ctl);
    checkOutput("sramDqO", sram_dq_o, e_dqo);
    checkOutput("dlFull", dl_full, m_buf);
    checkOutput("dlOvr", dl_ovr, m_ovr);
    checkOutput("rdAck", rd_ack, m_ack);
    if (m_ack != '0) checkOutput("rdD", rd_d, m_rdd);
    if (rd_ack != '0) dut_grants.push_back(rd_ack[1] ? 1 : 0);
  endtask

  task automatic tick();
    @(posedge clock);
    modelStep();
    #1;
    cyc++;
    checkCycle();
  endtask

  task automatic applyStimulus();
    reset     = ($urandom_range(199) == 0);
    dl_wr     = ($urandom_range(4) == 0);
    dl_a      = BW'($urandom);
    dl_d      = 8'($urandom);
    sram_dq_i = 16'($urandom);
    for (int c = 0; c < CH; c++) begin
      if (m_ack[c] && $urandom_range(1) == 0) rd_req[c] = 1'b0;
      else if (!rd_req[c]) begin
        if ($urandom_range(3) == 0) begin
          rd_req[c] = 1'b1;
          rd_a[c*BW +: BW] = BW'($urandom);
        end
      end else if ($urandom_range(15) == 0) rd_req[c] = 1'b0;
    end
  endtask

  initial begin
    int we_low;
    reset = 1'b1; dl_wr = 1'b0; dl_a = '0; dl_d = '0; rd_req = '0; rd_a = '0; sram_dq_i = '0;
    m_slot = 0; m_read = 0; m_buf = 0; m_ovr = 0; m_ack = '0; m_rdd = '0; m_rr = 0;
    m_last = 0; m_chan = 0; m_addr = '0; m_buf_a = '0; m_data = '0; m_buf_d = '0;
    repeat (2) tick();
    checkOutput("rst_we", sram_we, 1);
    checkOutput("rst_oe", sram_oe, 1);
    checkOutput("rst_ublb", {sram_ub, sram_lb}, 2'b11);
    checkOutput("rst_dqoe", sram_dq_oe, 0);
    checkOutput("rst_rdD", rd_d, 0);
    reset = 1'b0;
    repeat (20) tick();

    // Upper-lane write at byte address 3.
    dl_wr = 1'b1; dl_a = BW'(3); dl_d = 8'hA5;
    tick();
    dl_wr = 1'b0;
    checkOutput("wr_sramA", sram_a, 1);
    checkOutput("wr_ub", sram_ub, 0);
    checkOutput("wr_lb", sram_lb, 1);
    checkOutput("wr_dqo", sram_dq_o, 16'hA5A5);
    checkOutput("wr_we_first", sram_we, 0);
    checkOutput("wr_dlFull", dl_full, 0);
    tick();
    checkOutput("wr_we_last", sram_we, 1);
    checkOutput("wr_dqoe_last", sram_dq_oe, 1);
    tick();
    checkOutput("wr_idle_dqoe", sram_dq_oe, 0);

    // Lower-lane read on channel 1.
    rd_a[BW +: BW] = BW'(2); rd_req = 2'b10; sram_dq_i = 16'h3C7E;
    tick();
    checkOutput("rd_oe", sram_oe, 0);
    tick();
    tick();
    checkOutput("rd_ack", rd_ack, 2'b10);
    checkOutput("rd_data", rd_d, 8'h7E);
    rd_req = 2'b00;
    tick();
    checkOutput("rd_ack_width", rd_ack, 2'b00);

    // Two strobes during a read slot: one buffered, one dropped.
    rd_a[0 +: BW] = BW'(21'h00040); rd_req = 2'b01;
    tick();
    dl_wr = 1'b1; dl_a = BW'(21'h10); dl_d = 8'h11;
    tick();
    checkOutput("ovr_full", dl_full, 1);
    dl_a = BW'(21'h20); dl_d = 8'h22;
    tick();
    checkOutput("ovr_flag", dl_ovr, 1);
    dl_wr = 1'b0; rd_req = 2'b00;
    we_low = 0;
    repeat (8) begin
      tick();
      if (sram_we == 1'b0) we_low++;
    end
    checkOutput("ovr_one_write", we_low, AC - 1);

    // Both channels requesting continuously.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dut_grants.delete();
    rd_a = {BW'(21'h00201), BW'(21'h00100)};
    rd_req = 2'b11;
    repeat (19) tick();
    rd_req = 2'b00;
    repeat (6) tick();
    checkOutput("grant_count", dut_grants.size() >= 6, 1);
    for (int k = 0; k < 6 && k < dut_grants.size(); k++) begin
`ifdef SRAM_ARBITER_RR_EN
      checkOutput($sformatf("grant%0d", k), dut_grants[k], k % 2);
`else
      checkOutput($sformatf("grant%0d", k), dut_grants[k], 0);
`endif
    end

    // Reset during the first cycle of a write slot.
    dl_wr = 1'b1; dl_a = BW'(4); dl_d = 8'h5A;
    tick();
    dl_wr = 1'b0;
    checkOutput("rstmid_we_before", sram_we, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rstmid_we", sram_we, 1);
    checkOutput("rstmid_full", dl_full, 0);
    checkOutput("rstmid_ack", rd_ack, 0);
    tick();
    checkOutput("rstmid_idle", sram_dq_oe, 0);

    repeat (3000) begin
      applyStimulus();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
